// File: rtl/pmp_check_ctrl.sv
// PMP check controller: a locked-aware PMP entry register file plus a
// sequential scanner that checks one entry per cycle with a shared matcher.
// Each entry's match result is registered before the decision is taken, so a
// hit on entry k responds k+2 cycles after the accept edge.
module pmp_check_ctrl #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx,
  input  logic [1:0]                     cfg_mode,
  input  logic [2:0]                     cfg_perm,
  input  logic                           cfg_lock,
  input  logic [31:0]                    cfg_addr,
  output logic                           cfg_busy,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [33:0]                    req_addr,
  input  logic [1:0]                     req_size,
  input  logic [1:0]                     req_type,
  input  logic                           req_priv_m,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_allow,
  output logic                           rsp_hit,
  output logic [$clog2(NUM_ENTRIES)-1:0] rsp_idx
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_TOR   = 2'b01;
  localparam logic [1:0] MODE_NA4   = 2'b10;
  localparam logic [1:0] MODE_NAPOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Count of consecutive ones starting from bit 0 (32 for all-ones).
  function automatic logic [5:0] trail_ones(input logic [31:0] a);
    logic [5:0] n;
    logic       run;
    n   = 6'd0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (run && a[i]) begin
        n = n + 6'd1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  // Permission decision for an access that hit an entry.
  function automatic logic hit_allow(input logic priv_m, input logic lock,
                                     input logic [2:0] perm, input logic [1:0] acc);
    logic a;
    case (acc)
      2'b00:   a = (priv_m && !lock) ? 1'b1 : perm[0];
      2'b01:   a = (priv_m && !lock) ? 1'b1 : perm[1];
      2'b10:   a = (priv_m && !lock) ? 1'b1 : perm[2];
      default: a = 1'b0;
    endcase
    return a;
  endfunction

  // Entry register file
  logic [1:0]  mode_q [NUM_ENTRIES];
  logic [2:0]  perm_q [NUM_ENTRIES];
  logic        lock_q [NUM_ENTRIES];
  logic [31:0] eaddr_q[NUM_ENTRIES];

  // Request / scan / response state
  state_e        state_q, state_d;
  logic [33:0]   raddr_q, raddr_d;
  logic [1:0]    rsize_q, rsize_d;
  logic [1:0]    rtype_q, rtype_d;
  logic          rpriv_q, rpriv_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic          ev_valid_q, ev_valid_d;
  logic          ev_hit_q, ev_hit_d;
  logic [IW-1:0] ev_idx_q, ev_idx_d;
  logic          rsp_allow_q, rsp_allow_d;
  logic          rsp_hit_q, rsp_hit_d;
  logic [IW-1:0] rsp_idx_q, rsp_idx_d;

  // Config write qualification
  logic [IW:0] nxt_idx;
  logic        nxt_tor_locked;
  logic        cfg_wr;

  // Shared matcher signals
  logic [32:0]   lb, ub, region_lo, region_hi, napot_mask;
  logic [5:0]    napot_t;
  logic [IW-1:0] prev_idx;
  logic          match;

  // Decide whether a config write lands: idle only, and not on a locked
  // entry or the base of a locked TOR entry above it.
  always_comb begin
    nxt_idx = {1'b0, cfg_idx} + {{IW{1'b0}}, 1'b1};
    if (int'(nxt_idx) < NUM_ENTRIES) begin
      nxt_tor_locked = lock_q[nxt_idx[IW-1:0]] && (mode_q[nxt_idx[IW-1:0]] == MODE_TOR);
    end else begin
      nxt_tor_locked = 1'b0;
    end
    if ((int'(cfg_idx) < NUM_ENTRIES) && cfg_we && (state_q == S_IDLE)) begin
      cfg_wr = !lock_q[cfg_idx] && !nxt_tor_locked;
    end else begin
      cfg_wr = 1'b0;
    end
  end

  // Entry register file update; cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mode_q[i]  <= MODE_OFF;
        perm_q[i]  <= 3'b000;
        lock_q[i]  <= 1'b0;
        eaddr_q[i] <= 32'h0;
      end
    end else if (cfg_wr) begin
      mode_q[cfg_idx]  <= cfg_mode;
      perm_q[cfg_idx]  <= cfg_perm;
      lock_q[cfg_idx]  <= cfg_lock;
      eaddr_q[cfg_idx] <= cfg_addr;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mode_q[i]  <= mode_q[i];
        perm_q[i]  <= perm_q[i];
        lock_q[i]  <= lock_q[i];
        eaddr_q[i] <= eaddr_q[i];
      end
    end
  end

  // Single matcher: region of the entry at scan_idx_q against the access span.
  always_comb begin
    lb         = {1'b0, raddr_q[33:2]};
    ub         = lb + (33'd1 << rsize_q) - 33'd1;
    prev_idx   = scan_idx_q - IW'(1);
    napot_t    = trail_ones(eaddr_q[scan_idx_q]);
    napot_mask = (33'd1 << (napot_t + 6'd1)) - 33'd1;
    region_lo  = 33'd0;
    region_hi  = 33'd0;
    case (mode_q[scan_idx_q])
      MODE_TOR: begin
        if (scan_idx_q == '0) begin
          region_lo = 33'd0;
        end else begin
          region_lo = {1'b0, eaddr_q[prev_idx]};
        end
        region_hi = {1'b0, eaddr_q[scan_idx_q]};
      end
      MODE_NA4: begin
        region_lo = {1'b0, eaddr_q[scan_idx_q]};
        region_hi = {1'b0, eaddr_q[scan_idx_q]} + 33'd4;
      end
      MODE_NAPOT: begin
        if (napot_t == 6'd32) begin
          region_lo = 33'd0;
          region_hi = 33'h1_0000_0000;
        end else begin
          region_lo = {1'b0, eaddr_q[scan_idx_q]} & ~napot_mask;
          region_hi = ({1'b0, eaddr_q[scan_idx_q]} & ~napot_mask) + napot_mask + 33'd1;
        end
      end
      default: begin
        region_lo = 33'd0;
        region_hi = 33'd0;
      end
    endcase
    if (mode_q[scan_idx_q] == MODE_OFF) begin
      match = 1'b0;
    end else begin
      match = (lb >= region_lo) && (ub < region_hi);
    end
  end

  // FSM next state, scan bookkeeping and response latching.
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    rsize_d     = rsize_q;
    rtype_d     = rtype_q;
    rpriv_d     = rpriv_q;
    scan_idx_d  = scan_idx_q;
    ev_valid_d  = ev_valid_q;
    ev_hit_d    = ev_hit_q;
    ev_idx_d    = ev_idx_q;
    rsp_allow_d = rsp_allow_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_SCAN;
          raddr_d    = req_addr;
          rsize_d    = req_size;
          rtype_d    = req_type;
          rpriv_d    = req_priv_m;
          scan_idx_d = '0;
          ev_valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (ev_valid_q && ev_hit_q) begin
          state_d     = S_RESP;
          rsp_hit_d   = 1'b1;
          rsp_idx_d   = ev_idx_q;
          rsp_allow_d = hit_allow(rpriv_q, lock_q[ev_idx_q], perm_q[ev_idx_q], rtype_q);
        end else if (ev_valid_q && (ev_idx_q == LAST_IDX)) begin
          state_d     = S_RESP;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = '0;
          rsp_allow_d = rpriv_q;
        end else begin
          ev_valid_d = 1'b1;
          ev_hit_d   = match;
          ev_idx_d   = scan_idx_q;
          if (scan_idx_q != LAST_IDX) begin
            scan_idx_d = scan_idx_q + IW'(1);
          end else begin
            scan_idx_d = scan_idx_q;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      raddr_q     <= 34'h0;
      rsize_q     <= 2'b00;
      rtype_q     <= 2'b00;
      rpriv_q     <= 1'b0;
      scan_idx_q  <= '0;
      ev_valid_q  <= 1'b0;
      ev_hit_q    <= 1'b0;
      ev_idx_q    <= '0;
      rsp_allow_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      rsize_q     <= rsize_d;
      rtype_q     <= rtype_d;
      rpriv_q     <= rpriv_d;
      scan_idx_q  <= scan_idx_d;
      ev_valid_q  <= ev_valid_d;
      ev_hit_q    <= ev_hit_d;
      ev_idx_q    <= ev_idx_d;
      rsp_allow_q <= rsp_allow_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

  assign cfg_busy  = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_allow = rsp_allow_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;

endmodule
